// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selector and
// elaboration-time helpers used for parameter sanity checks.
package fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // True when v is a power of two and at least 2.
    function automatic bit is_pow2_ge2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read.
// Contents are never reset; the pointers in fifo_flags decide what is valid.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, sticky overflow/underflow and a choice of
// registered (STD) or first-word-fall-through (FWFT) read port.
//
// Handshake: enable style, no back-pressure on the request itself.
// A write is taken when wr_en is high and full is low at the clock edge;
// a read is taken when rd_en is high and empty is low at the clock edge.
// Requests made against full/empty are dropped and recorded in the sticky
// overflow/underflow flags. valid marks data_out as a word to consume:
// STD pulses valid for the one cycle after an accepted read, FWFT holds
// valid while the FIFO is non-empty and rd_en acknowledges the head word.
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         DEPTH    = 8,
    parameter fifo_mode_e MODE     = FIFO_STD,
    parameter int         AF_LEVEL = DEPTH - 1,
    parameter int         AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // Reject parameter sets that the pointer/flag logic cannot honour.
    if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
        $error("fifo_flags: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flags: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flags: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_flags: WIDTH must be at least 1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] head_word;

    // Flags come from the count register alone, so they only move on edges.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses the pre-edge flags: no write-through in either direction.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    // Pointers wrap naturally at DEPTH; count tracks occupancy separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags: a new offending request beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (wr_en & full)  | (overflow_q  & ~clr_err);
            underflow_q <= (rd_en & empty) | (underflow_q & ~clr_err);
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] data_q;
        logic             valid_q;

        // Registered read port: an accepted read presents its word next cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_q <= head_word;
                end
            end
        end

        assign data_out = data_q;
        assign valid    = valid_q;
    end else begin : g_fwft
        // Head word shown directly; forced to zero while empty so the port
        // reads back its reset value rather than stale array contents.
        assign data_out = empty ? '0 : head_word;
        assign valid    = ~empty;
    end

endmodule
